// File: rtl/seq_multiplier_32_pkg.sv
// seq_multiplier_32_pkg: shared width, iteration bound and FSM encoding for the sequential multiplier
package seq_multiplier_32_pkg;
    localparam int WIDTH = 32;
    localparam logic [4:0] LAST_ITER = 5'd31;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/FullAdder_32.sv
// FullAdder_32: 32-bit ripple-carry adder
module FullAdder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[32];
endmodule

// File: rtl/seq_multiplier_32.sv
// seq_multiplier_32: unsigned 32x32->64 shift-add multiplier, one adder, 32 iterations
module seq_multiplier_32 #(
    parameter int WIDTH = seq_multiplier_32_pkg::WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    import seq_multiplier_32_pkg::*;

    if (WIDTH != 32) begin : g_width_check
        $error("seq_multiplier_32 supports only WIDTH=32");
    end

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d, a_q, a_d, q_q, q_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] product_q, product_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] add_sum;
    logic        add_cout;

    FullAdder_32 u_adder (
        .a   (a_q),
        .b   (m_q),
        .cin (1'b0),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = BUSY;
                m_d     = a;
                q_d     = b;
                a_d     = '0;
                count_d = '0;
            end
            BUSY: begin
                // carry-out lands in A[31] after the shift, so the 33-bit sum is never lost
                {a_d, q_d} = {q_q[0] ? {add_cout, add_sum} : {1'b0, a_q}, q_q[31:1]};
                count_d    = count_q + 5'd1;
                if (count_q == LAST_ITER) begin
                    product_d = {a_d, q_d};
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == BUSY;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier_32.sv
// tb_seq_multiplier_32: randomized and directed checks against an arithmetic product model
module tb_seq_multiplier_32;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [63:0] product;
    int          tests = 0;
    int          fails = 0;
    logic [63:0] exp_prod = '0;

    always #5 clk = ~clk;

    seq_multiplier_32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    function automatic logic [63:0] model_mul(input logic [31:0] x, input logic [31:0] y);
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Starts (optionally) an operation and watches the 33 edges after its accepting edge E0.
    // A second start is driven for edge E_again; for again==33 it is left high on return.
    task automatic run_op(input bit launch, input logic [31:0] x, input logic [31:0] y,
                          input int again, input logic [31:0] x2, input logic [31:0] y2,
                          output int dcyc, output int dcnt, output logic [63:0] p32,
                          output logic [63:0] p33, output int busy_bad, output int held_bad);
        dcyc = -1; dcnt = 0; busy_bad = 0; held_bad = 0; p32 = '0; p33 = '0;
        if (launch) begin
            start = 1'b1; a = x; b = y;
            @(posedge clk); @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom;
        end
        if (busy !== 1'b1) busy_bad++;
        for (int n = 1; n <= 33; n++) begin
            if (n == again) begin start = 1'b1; a = x2; b = y2; end
            @(posedge clk); @(negedge clk);
            if (n == again && n < 33) begin start = 1'b0; a = $urandom; b = $urandom; end
            if (done === 1'b1) begin dcnt++; if (dcyc < 0) dcyc = n; end
            if (busy !== (n < 32)) busy_bad++;
            if (n < 32 && product !== exp_prod) held_bad++;
            if (n == 32) p32 = product;
            if (n == 33) p33 = product;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (product !== 64'h0) begin fails++; $display("FAIL reset_product: got %h want 0", product); end
        rst = 1'b0;
        exp_prod = '0;
        @(negedge clk);
    endtask

    task automatic test_product(input logic [31:0] x, input logic [31:0] y, input string tag);
        int dc, dn, bb, hb;
        logic [63:0] p32, p33, want;
        want = model_mul(x, y);
        run_op(1'b1, x, y, -1, '0, '0, dc, dn, p32, p33, bb, hb);
        tests++; if (dc != 32) begin fails++; $display("FAIL %s done_cycle: got %0d want 32", tag, dc); end
        tests++; if (dn != 1) begin fails++; $display("FAIL %s done_count: got %0d want 1", tag, dn); end
        tests++; if (p32 !== want) begin fails++; $display("FAIL %s product: got %h want %h", tag, p32, want); end
        tests++; if (p33 !== want) begin fails++; $display("FAIL %s product_hold: got %h want %h", tag, p33, want); end
        tests++; if (bb != 0) begin fails++; $display("FAIL %s busy: got %0d bad cycles want 0", tag, bb); end
        tests++; if (hb != 0) begin fails++; $display("FAIL %s held_prev: got %0d bad cycles want 0", tag, hb); end
        exp_prod = want;
    endtask

    task automatic test_ignored_start();
        int dc, dn, bb, hb;
        logic [63:0] p32, p33;
        run_op(1'b1, 32'd7, 32'd9, 10, 32'd1, 32'd1, dc, dn, p32, p33, bb, hb);
        tests++; if (dc != 32 || dn != 1) begin fails++; $display("FAIL ignore_done: got cycle %0d count %0d want 32/1", dc, dn); end
        tests++; if (p32 !== 64'd63) begin fails++; $display("FAIL ignore_product: got %h want %h", p32, 64'd63); end
        tests++; if (bb != 0) begin fails++; $display("FAIL ignore_busy: got %0d bad cycles want 0", bb); end
        exp_prod = 64'd63;
        repeat (5) @(negedge clk);
        tests++; if (product !== 64'd63 || done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL ignore_after: got product %h done %b busy %b want 63/0/0", product, done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start = 1'b1; a = 32'd6; b = 32'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
            fails++; $display("FAIL midreset_clear: got busy %b done %b product %h want 0/0/0", busy, done, product);
        end
        exp_prod = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midreset_quiet: got %0d active cycles want 0", seen); end
        test_product(32'd2, 32'd2, "after_reset");
    endtask

    task automatic test_back_to_back();
        int dc, dn, bb, hb;
        logic [63:0] p32, p33;
        // start held across the DONE edge (ignored) and the following IDLE edge (accepted)
        run_op(1'b1, 32'd10, 32'd10, 33, 32'd4, 32'd4, dc, dn, p32, p33, bb, hb);
        tests++; if (dc != 32 || p32 !== 64'd100) begin fails++; $display("FAIL b2b_first: got cycle %0d product %h want 32/%h", dc, p32, 64'd100); end
        exp_prod = 64'd100;
        @(posedge clk); @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        run_op(1'b0, '0, '0, -1, '0, '0, dc, dn, p32, p33, bb, hb);
        tests++; if (dc != 32 || dn != 1) begin fails++; $display("FAIL b2b_second_done: got cycle %0d count %0d want 32/1", dc, dn); end
        tests++; if (p32 !== 64'd16) begin fails++; $display("FAIL b2b_second_product: got %h want %h", p32, 64'd16); end
        tests++; if (hb != 0) begin fails++; $display("FAIL b2b_held: got %0d bad cycles want 0", hb); end
        tests++; if (bb != 0) begin fails++; $display("FAIL b2b_busy: got %0d bad cycles want 0", bb); end
        exp_prod = 64'd16;
    endtask

    task automatic test_random();
        logic [31:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            y = $urandom;
            if (i == 0) y = 32'd1;
            if (i == 1) x = 32'hFFFF_FFFF;
            test_product(x, y, "random");
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_product(32'd3, 32'd5, "basic");
        test_product(32'hFFFF_FFFF, 32'hFFFF_FFFF, "all_ones");
        test_product(32'h8000_0000, 32'd2, "msb_shift");
        test_product(32'd0, 32'h1234_5678, "zero");
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
